axis_width_fifo: RTL and testbench
==================================

# axis_width_fifo

Parametrised AXI-Stream buffer and width converter: the next generation of the `pipelined_reg` stage that sits between `axis_image_vip` source and sink in the bench. It accepts INPUT_BYTES-wide beats and emits OUTPUT_BYTES-wide beats through a DEPTH-entry FIFO. It packs (upsize) or unpacks (downsize) by an integer ratio, preserving TLAST framing and reporting partial final beats through a byte keep.

## Interface
- INPUT_BYTES, 4, slave data width in bytes
- OUTPUT_BYTES, 4, master data width in bytes; max(IN,OUT) must be an integer multiple of min(IN,OUT)
- DEPTH, 4, FIFO entries (power of two, ≥2), each entry max(IN,OUT) bytes wide
- clk_i  in  1  clock, all logic rising-edge
- rstn_i  in  1  reset, synchronous, active-low
- axis_s_data_i  in  INPUT_BYTES*8  slave data
- axis_s_valid_i  in  1  slave valid
- axis_s_ready_o  out  1  slave ready
- axis_s_last_i  in  1  slave end-of-packet
- axis_m_data_o  out  OUTPUT_BYTES*8  master data
- axis_m_keep_o  out  OUTPUT_BYTES  byte-valid mask for master data
- axis_m_valid_o  out  1  master valid
- axis_m_ready_i  in  1  master ready
- axis_m_last_o  out  1  master end-of-packet
- level_o  out  $clog2(DEPTH)+1  current FIFO entry count

## Operation
- Handshake: transfer when valid && ready on a rising edge. Master holds data/keep/last stable while valid && !ready. Valid never depends combinationally on ready.
- RATIO = max/min. Mode is selected at elaboration: EQUAL (IN==OUT), UP (OUT>IN), DOWN (IN>OUT).
- axis_s_ready_o = !full && in reset-released state. A push is never accepted while full, even with a simultaneous pop.
- EQUAL: plain FIFO. keep is all ones.
- UP: packer register plus beat counter (0..RATIO-1). Beat k goes to byte lane slice k; the first beat lands in the LSBs.
  - On an accepted beat with counter==RATIO-1 or last=1, the word (packer contents merged with the incoming beat) is pushed in the same cycle.
  - The entry stores keep = ones for lanes 0..(k+1)*IN-1 and zeros above. Unfilled lanes are zero data.
  - The counter clears and the packer clears to zero after each push.
- DOWN: the FIFO stores full input words plus last. The unpacker slice counter (0..RATIO-1) selects output slice = entry bits [(c+1)*OUT*8-1 : c*OUT*8].
  - axis_m_last_o = entry.last && c==RATIO-1. keep is all ones.
  - An entry is popped when slice RATIO-1 is accepted. The counter then returns to 0.
- level_o counts FIFO entries: +1 on push, −1 on pop, unchanged on simultaneous push and pop. The DOWN head entry counts until its last slice pops.
- Pointers wrap modulo DEPTH. Full when level==DEPTH; empty when level==0.

## Timing
- Reset (rstn_i low at a rising edge): all pointers, counters and the packer are cleared. Next cycle: axis_s_ready_o=0 while rstn_i is low, axis_m_valid_o=0, axis_m_data_o=0, axis_m_keep_o=0, axis_m_last_o=0, level_o=0.
- First cycle after rstn_i is sampled high: axis_s_ready_o=1.
- Reset mid-packet discards everything, including the partial packer word and the partial unpack.
- Latency: output valid appears 1 cycle after the push edge. In UP, that is the edge accepting the completing or last beat. The output is registered from FIFO memory with no combinational s→m path.
- Throughput:
  - EQUAL and DOWN sustain 1 output beat per cycle when the sink is always ready.
  - UP sustains 1 input beat per cycle.
  - The FIFO sustains concurrent push/pop in the same cycle at any level below DEPTH.
- Full: ready deasserts the cycle after the push that makes level==DEPTH. It reasserts the cycle after the first pop.
- Empty: valid drops the cycle after the pop that makes level 0, unless a push occurs in that same cycle.

## Test plan
- EQUAL (4→4, DEPTH 4): stream 0x00000001..0x00000010, last on beat 16, sink always ready → identical sequence out, 1-cycle latency, keep=0xF, last on the 16th beat, level_o ≤1.
- UP (1→4): send bytes 0x11,0x22,0x33,0x44,0x55,0x66 with last on 0x66 → out 0x44332211 keep 0xF last 0, then 0x00006655 keep 0x3 last 1.
- DOWN (4→1): send 0xDDCCBBAA last=1 → out 0xAA,0xBB,0xCC,0xDD on consecutive cycles, last only with 0xDD.
- Backpressure (EQUAL, DEPTH 4): sink ready=0, push 6 beats → 4 accepted, ready=0 with level_o=4. Release ready → all 4 drain in order, then remaining 2 accepted. No loss or duplication.
- Reset mid-operation (UP 1→4): push 0x11,0x22, then pulse rstn_i low for 1 cycle → no output. Subsequent 0xA1..0xA4 → single word 0xA4A3A2A1.
- Random: random valid/ready (50%), all three modes, 1000 packets. Scoreboard compares byte stream and last positions; assert stability while stalled.

Source files
------------

// File: rtl/axis_width_fifo.sv
// AXI-Stream FIFO with integer-ratio width conversion.
// Upsizing packs narrow beats into a wide entry before the FIFO; downsizing
// stores wide entries and unpacks them slice by slice at the output.
// One datapath serves all three modes: the pack counter only runs when
// upsizing and the slice counter only when downsizing, so in the other modes
// each counter stays at 0 and its part-selects cover the whole word.
module axis_width_fifo #(
    parameter int INPUT_BYTES  = 4,
    parameter int OUTPUT_BYTES = 4,
    parameter int DEPTH        = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [INPUT_BYTES*8-1:0]   axis_s_data_i,
    input  logic                       axis_s_valid_i,
    output logic                       axis_s_ready_o,
    input  logic                       axis_s_last_i,
    output logic [OUTPUT_BYTES*8-1:0]  axis_m_data_o,
    output logic [OUTPUT_BYTES-1:0]    axis_m_keep_o,
    output logic                       axis_m_valid_o,
    input  logic                       axis_m_ready_i,
    output logic                       axis_m_last_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    typedef enum logic [1:0] {MODE_EQUAL, MODE_UP, MODE_DOWN} mode_e;

    localparam int IB    = INPUT_BYTES;
    localparam int OB    = OUTPUT_BYTES;
    localparam int WB    = (IB > OB) ? IB : OB;
    localparam int NB    = (IB > OB) ? OB : IB;
    localparam int RATIO = WB / NB;
    localparam mode_e MODE = (IB == OB) ? MODE_EQUAL : ((OB > IB) ? MODE_UP : MODE_DOWN);
    localparam int UPR   = (MODE == MODE_UP)   ? RATIO : 1;
    localparam int DNR   = (MODE == MODE_DOWN) ? RATIO : 1;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    localparam logic [CW-1:0] BEAT_LAST  = CW'(UPR - 1);
    localparam logic [CW-1:0] SLICE_LAST = CW'(DNR - 1);
    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);

    logic [WB*8-1:0] r_mem_data [DEPTH];
    logic [WB-1:0]   r_mem_keep [DEPTH];
    logic            r_mem_last [DEPTH];

    logic            r_run;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [CW-1:0]   r_beat;
    logic [CW-1:0]   r_slice;
    logic [WB*8-1:0] r_pack;

    logic            w_full;
    logic            w_s_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_m_valid;
    logic            w_m_hs;
    logic            w_pop;
    logic [WB*8-1:0] w_merged;
    logic [WB-1:0]   w_keep;
    logic [WB*8-1:0] w_head_data;
    logic [WB-1:0]   w_head_keep;
    logic            w_head_last;

    assign w_full    = (r_level == FULL_LVL);
    assign w_s_ready = r_run && !w_full;
    assign w_accept  = axis_s_valid_i && w_s_ready;
    assign w_push    = w_accept && ((r_beat == BEAT_LAST) || axis_s_last_i);
    assign w_m_valid = (r_level != '0);
    assign w_m_hs    = w_m_valid && axis_m_ready_i;
    assign w_pop     = w_m_hs && (r_slice == SLICE_LAST);

    assign w_head_data = r_mem_data[r_rd_ptr];
    assign w_head_keep = r_mem_keep[r_rd_ptr];
    assign w_head_last = r_mem_last[r_rd_ptr];

    // Merge the incoming beat into its lane slice and build the lane mask.
    always_comb begin
        w_merged = r_pack;
        w_merged[r_beat*IB*8 +: IB*8] = axis_s_data_i;
        w_keep = '0;
        for (int unsigned j = 0; j < WB; j++) begin
            w_keep[j] = (j < (32'(r_beat) + 32'd1) * 32'(IB));
        end
    end

    // FIFO storage; not reset, outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_merged;
            r_mem_keep[r_wr_ptr] <= w_keep;
            r_mem_last[r_wr_ptr] <= axis_s_last_i;
        end
    end

    // Pointers, occupancy and the reset-released flag.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_run    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Packer: accumulate beats until the word completes or the packet ends.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_beat <= '0;
            r_pack <= '0;
        end else if (w_accept) begin
            if (w_push) begin
                r_beat <= '0;
                r_pack <= '0;
            end else begin
                r_beat <= r_beat + 1'b1;
                r_pack <= w_merged;
            end
        end
    end

    // Unpacker: step through output slices of the head entry.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_slice <= '0;
        end else if (w_m_hs) begin
            if (r_slice == SLICE_LAST) r_slice <= '0;
            else                       r_slice <= r_slice + 1'b1;
        end
    end

    assign axis_s_ready_o = w_s_ready;
    assign axis_m_valid_o = w_m_valid;
    assign axis_m_data_o  = w_m_valid ? w_head_data[r_slice*OB*8 +: OB*8] : '0;
    assign axis_m_keep_o  = w_m_valid ? w_head_keep[r_slice*OB +: OB] : '0;
    assign axis_m_last_o  = w_m_valid && w_head_last && (r_slice == SLICE_LAST);
    assign level_o        = r_level;

endmodule

// File: tb/tb_axis_width_fifo.sv
// Directed and randomized checks of axis_width_fifo in equal, upsize (1->4)
// and downsize (4->1) configurations.
module tb_axis_width_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] e_s_data, e_m_data;
    logic [3:0]  e_m_keep;
    logic        e_s_valid, e_s_ready, e_s_last, e_m_valid, e_m_ready, e_m_last;
    logic [2:0]  e_level;

    logic [7:0]  u_s_data;
    logic [31:0] u_m_data;
    logic [3:0]  u_m_keep;
    logic        u_s_valid, u_s_ready, u_s_last, u_m_valid, u_m_ready, u_m_last;
    logic [2:0]  u_level;

    logic [31:0] d_s_data;
    logic [7:0]  d_m_data;
    logic [0:0]  d_m_keep;
    logic        d_s_valid, d_s_ready, d_s_last, d_m_valid, d_m_ready, d_m_last;
    logic [2:0]  d_level;

    axis_width_fifo #(.INPUT_BYTES(4), .OUTPUT_BYTES(4), .DEPTH(4)) u_eq (
        .clk_i(clk), .rstn_i(rstn),
        .axis_s_data_i(e_s_data), .axis_s_valid_i(e_s_valid), .axis_s_ready_o(e_s_ready),
        .axis_s_last_i(e_s_last), .axis_m_data_o(e_m_data), .axis_m_keep_o(e_m_keep),
        .axis_m_valid_o(e_m_valid), .axis_m_ready_i(e_m_ready), .axis_m_last_o(e_m_last),
        .level_o(e_level)
    );

    axis_width_fifo #(.INPUT_BYTES(1), .OUTPUT_BYTES(4), .DEPTH(4)) u_up (
        .clk_i(clk), .rstn_i(rstn),
        .axis_s_data_i(u_s_data), .axis_s_valid_i(u_s_valid), .axis_s_ready_o(u_s_ready),
        .axis_s_last_i(u_s_last), .axis_m_data_o(u_m_data), .axis_m_keep_o(u_m_keep),
        .axis_m_valid_o(u_m_valid), .axis_m_ready_i(u_m_ready), .axis_m_last_o(u_m_last),
        .level_o(u_level)
    );

    axis_width_fifo #(.INPUT_BYTES(4), .OUTPUT_BYTES(1), .DEPTH(4)) u_dn (
        .clk_i(clk), .rstn_i(rstn),
        .axis_s_data_i(d_s_data), .axis_s_valid_i(d_s_valid), .axis_s_ready_o(d_s_ready),
        .axis_s_last_i(d_s_last), .axis_m_data_o(d_m_data), .axis_m_keep_o(d_m_keep),
        .axis_m_valid_o(d_m_valid), .axis_m_ready_i(d_m_ready), .axis_m_last_o(d_m_last),
        .level_o(d_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic up_send(input logic [7:0] b, input logic l);
        u_s_data  = b;
        u_s_valid = 1'b1;
        u_s_last  = l;
        tick();
        u_s_valid = 1'b0;
        u_s_last  = 1'b0;
    endtask

    initial begin
        logic [31:0] dword;
        rstn = 1'b0;
        e_s_data = '0; e_s_valid = 0; e_s_last = 0; e_m_ready = 1;
        u_s_data = '0; u_s_valid = 0; u_s_last = 0; u_m_ready = 1;
        d_s_data = '0; d_s_valid = 0; d_s_last = 0; d_m_ready = 1;
        tick();
        tick();

        // reset state
        chk("rst_eq_ready", e_s_ready, 0);
        chk("rst_eq_valid", e_m_valid, 0);
        chk("rst_eq_data",  e_m_data, 0);
        chk("rst_eq_keep",  e_m_keep, 0);
        chk("rst_eq_last",  e_m_last, 0);
        chk("rst_eq_level", e_level, 0);
        chk("rst_up_ready", u_s_ready, 0);
        chk("rst_up_valid", u_m_valid, 0);
        chk("rst_up_keep",  u_m_keep, 0);
        chk("rst_dn_ready", d_s_ready, 0);
        chk("rst_dn_valid", d_m_valid, 0);
        chk("rst_dn_data",  d_m_data, 0);
        rstn = 1'b1;
        tick();
        chk("rel_eq_ready", e_s_ready, 1);
        chk("rel_up_ready", u_s_ready, 1);
        chk("rel_dn_ready", d_s_ready, 1);

        // equal mode streaming, sink always ready
        for (int i = 1; i <= 16; i++) begin
            e_s_data  = 32'(i);
            e_s_valid = 1'b1;
            e_s_last  = (i == 16);
            chk("eq_s_ready", e_s_ready, 1);
            tick();
            chk("eq_valid", e_m_valid, 1);
            chk("eq_data",  e_m_data, 32'(i));
            chk("eq_keep",  e_m_keep, 4'hF);
            chk("eq_last",  e_m_last, (i == 16) ? 1 : 0);
            chk("eq_level", e_level, 1);
        end
        e_s_valid = 1'b0;
        e_s_last  = 1'b0;
        tick();
        chk("eq_drain_valid", e_m_valid, 0);
        chk("eq_drain_level", e_level, 0);

        // upsize 1->4 with a partial final word
        up_send(8'h11, 0);
        up_send(8'h22, 0);
        up_send(8'h33, 0);
        chk("up_no_early_valid", u_m_valid, 0);
        up_send(8'h44, 0);
        chk("up_w1_valid", u_m_valid, 1);
        chk("up_w1_data",  u_m_data, 32'h44332211);
        chk("up_w1_keep",  u_m_keep, 4'hF);
        chk("up_w1_last",  u_m_last, 0);
        chk("up_w1_level", u_level, 1);
        up_send(8'h55, 0);
        chk("up_gap_valid", u_m_valid, 0);
        up_send(8'h66, 1);
        chk("up_w2_valid", u_m_valid, 1);
        chk("up_w2_data",  u_m_data, 32'h00006655);
        chk("up_w2_keep",  u_m_keep, 4'h3);
        chk("up_w2_last",  u_m_last, 1);
        tick();
        chk("up_end_valid", u_m_valid, 0);
        chk("up_end_level", u_level, 0);

        // downsize 4->1
        dword     = 32'hDDCCBBAA;
        d_s_data  = dword;
        d_s_valid = 1'b1;
        d_s_last  = 1'b1;
        tick();
        d_s_valid = 1'b0;
        d_s_last  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("dn_valid", d_m_valid, 1);
            chk("dn_data",  d_m_data, dword[k*8 +: 8]);
            chk("dn_keep",  d_m_keep, 1);
            chk("dn_last",  d_m_last, (k == 3) ? 1 : 0);
            chk("dn_level", d_level, 1);
            tick();
        end
        chk("dn_end_valid", d_m_valid, 0);
        chk("dn_end_level", d_level, 0);

        // backpressure on equal mode: fill, stall, then drain
        e_m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e_s_data  = 32'hA0 + 32'(i);
            e_s_valid = 1'b1;
            chk("bp_fill_ready", e_s_ready, 1);
            tick();
            chk("bp_fill_level", e_level, 32'(i + 1));
        end
        e_s_data = 32'hA4;
        for (int s = 0; s < 2; s++) begin
            chk("bp_full_ready", e_s_ready, 0);
            tick();
            chk("bp_full_level", e_level, 4);
            chk("bp_stall_valid", e_m_valid, 1);
            chk("bp_stall_data", e_m_data, 32'hA0);
        end
        e_m_ready = 1'b1;
        tick();
        chk("bp_pop1_level", e_level, 3);
        chk("bp_pop1_data",  e_m_data, 32'hA1);
        chk("bp_reready",    e_s_ready, 1);
        tick();
        chk("bp_pp1_level", e_level, 3);
        chk("bp_pp1_data",  e_m_data, 32'hA2);
        e_s_data = 32'hA5;
        tick();
        chk("bp_pp2_level", e_level, 3);
        chk("bp_pp2_data",  e_m_data, 32'hA3);
        e_s_valid = 1'b0;
        tick();
        chk("bp_d1_data", e_m_data, 32'hA4);
        chk("bp_d1_level", e_level, 2);
        tick();
        chk("bp_d2_data", e_m_data, 32'hA5);
        chk("bp_d2_level", e_level, 1);
        tick();
        chk("bp_d3_valid", e_m_valid, 0);
        chk("bp_d3_level", e_level, 0);

        // reset in the middle of an upsize packet
        up_send(8'h11, 0);
        up_send(8'h22, 0);
        rstn = 1'b0;
        tick();
        chk("mr_ready", u_s_ready, 0);
        chk("mr_valid", u_m_valid, 0);
        chk("mr_level", u_level, 0);
        rstn = 1'b1;
        tick();
        chk("mr_rel_ready", u_s_ready, 1);
        chk("mr_rel_valid", u_m_valid, 0);
        up_send(8'hA1, 0);
        up_send(8'hA2, 0);
        up_send(8'hA3, 0);
        chk("mr_no_early", u_m_valid, 0);
        up_send(8'hA4, 0);
        chk("mr_valid_w", u_m_valid, 1);
        chk("mr_data",    u_m_data, 32'hA4A3A2A1);
        chk("mr_keep",    u_m_keep, 4'hF);
        tick();
        chk("mr_end_valid", u_m_valid, 0);

        // randomized upsize stream with byte scoreboard
        begin
            logic [8:0] uq[$];
            fork
                begin
                    int sent;
                    sent = 0;
                    for (int cyc = 0; cyc < 4000 && sent < 300; cyc++) begin
                        u_s_valid = 1'($urandom_range(0, 1));
                        u_s_data  = 8'(sent * 7 + 3);
                        u_s_last  = (sent == 299) || ($urandom_range(0, 3) == 0);
                        if (u_s_valid && u_s_ready) begin
                            uq.push_back({u_s_last, u_s_data});
                            sent++;
                        end
                        tick();
                    end
                    u_s_valid = 1'b0;
                    u_s_last  = 1'b0;
                end
                begin
                    int got;
                    logic pv, pl, le;
                    logic [31:0] pd;
                    logic [3:0] pk;
                    logic [8:0] e;
                    got = 0;
                    pv  = 1'b0;
                    for (int cyc = 0; cyc < 6000 && got < 300; cyc++) begin
                        if (pv) begin
                            chk("up_rand_hold_valid", u_m_valid, 1);
                            chk("up_rand_hold_data",  u_m_data, pd);
                            chk("up_rand_hold_keep",  u_m_keep, pk);
                            chk("up_rand_hold_last",  u_m_last, pl);
                        end
                        u_m_ready = 1'($urandom_range(0, 1));
                        if (u_m_valid && u_m_ready) begin
                            le = 1'b0;
                            for (int j = 0; j < 4; j++) begin
                                if (u_m_keep[j]) begin
                                    e = (uq.size() > 0) ? uq.pop_front() : 9'h1FF;
                                    chk("up_rand_byte", u_m_data[j*8 +: 8], e[7:0]);
                                    le = e[8];
                                    got++;
                                end
                            end
                            chk("up_rand_last", u_m_last, le);
                        end
                        pv = u_m_valid && !u_m_ready;
                        pd = u_m_data;
                        pk = u_m_keep;
                        pl = u_m_last;
                        tick();
                    end
                    chk("up_rand_count", got, 300);
                    u_m_ready = 1'b1;
                end
            join
        end

        // randomized downsize stream with byte scoreboard
        begin
            logic [8:0] dq[$];
            fork
                begin
                    int sent;
                    logic [7:0] b;
                    sent = 0;
                    for (int cyc = 0; cyc < 4000 && sent < 100; cyc++) begin
                        b = 8'(sent * 4);
                        d_s_valid = 1'($urandom_range(0, 1));
                        d_s_data  = {b + 8'd3, b + 8'd2, b + 8'd1, b};
                        d_s_last  = (sent == 99) || ($urandom_range(0, 2) == 0);
                        if (d_s_valid && d_s_ready) begin
                            for (int k = 0; k < 4; k++) begin
                                dq.push_back({d_s_last && (k == 3), d_s_data[k*8 +: 8]});
                            end
                            sent++;
                        end
                        tick();
                    end
                    d_s_valid = 1'b0;
                    d_s_last  = 1'b0;
                end
                begin
                    int got;
                    logic pv, pl;
                    logic [7:0] pd;
                    logic [8:0] e;
                    got = 0;
                    pv  = 1'b0;
                    for (int cyc = 0; cyc < 8000 && got < 400; cyc++) begin
                        if (pv) begin
                            chk("dn_rand_hold_valid", d_m_valid, 1);
                            chk("dn_rand_hold_data",  d_m_data, pd);
                            chk("dn_rand_hold_last",  d_m_last, pl);
                        end
                        d_m_ready = 1'($urandom_range(0, 1));
                        if (d_m_valid && d_m_ready) begin
                            e = (dq.size() > 0) ? dq.pop_front() : 9'h1FF;
                            chk("dn_rand_byte", d_m_data, e[7:0]);
                            chk("dn_rand_last", d_m_last, e[8]);
                            chk("dn_rand_keep", d_m_keep, 1);
                            got++;
                        end
                        pv = d_m_valid && !d_m_ready;
                        pd = d_m_data;
                        pl = d_m_last;
                        tick();
                    end
                    chk("dn_rand_count", got, 400);
                    d_m_ready = 1'b1;
                end
            join
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
